// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/acknowledge, decode-stage valid/ready,
// controller redirect, and a state debug tap.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  // memReq/memAck: once raised, memReq stays high with memAddr stable until a cycle
  // with memAck=1, and that cycle completes the transfer; memAck with memReq=0 means nothing.
  // instrValid/instrReady: a word transfers at each rising edge where both are 1;
  // instrReady with instrValid=0 means nothing. redirect overrides both.
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memReq;
  logic                  memAck;
  logic [15:0]           memData;
  logic [15:0]           instruction;
  logic                  instrValid;
  logic                  instrReady;
  logic [ADDR_WIDTH-1:0] pcOut;
  logic [ADDR_WIDTH-1:0] pcPlusOne;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirectAddr;
  logic [1:0]            fetchState;

  modport master (
    output memAddr, memReq, instruction, instrValid, pcOut, pcPlusOne, fetchState,
    input  memAck, memData, instrReady, redirect, redirectAddr
  );

  modport slave (
    input  memAddr, memReq, instruction, instrValid, pcOut, pcPlusOne, fetchState,
    output memAck, memData, instrReady, redirect, redirectAddr
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, single-outstanding memory fetch, holds one word for decode.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer (up to 1 instruction per cycle).
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2, DRAIN = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [15:0]           instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  mem_req;
  logic                  ack;
`ifdef FETCH_PREFETCH_EN
  logic [15:0]           buf_data_q, buf_data_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic                  buf_valid_q, buf_valid_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      pc_out_q     <= RESET_PC;
      instr_q      <= 16'h0000;
      valid_q      <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_data_q   <= 16'h0000;
      buf_addr_q   <= RESET_PC;
      buf_valid_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      pc_out_q     <= pc_out_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
`ifdef FETCH_PREFETCH_EN
      buf_data_q   <= buf_data_d;
      buf_addr_q   <= buf_addr_d;
      buf_valid_q  <= buf_valid_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    pc_out_d     = pc_out_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    mem_req      = (state_q == REQ) || (state_q == DRAIN);
`ifdef FETCH_PREFETCH_EN
    buf_data_d   = buf_data_q;
    buf_addr_d   = buf_addr_q;
    buf_valid_d  = buf_valid_q;
    mem_req      = mem_req || ((state_q == VALID) && !buf_valid_q);
`endif
    ack = bus.memAck && mem_req;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirectAddr;
          valid_d    = 1'b0;
          // An unacknowledged request cannot be withdrawn, so it is drained first.
          if (!ack) begin
            drain_addr_d = fetch_pc_q;
            state_d      = DRAIN;
          end
        end else if (ack) begin
          instr_d    = bus.memData;
          pc_out_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 1'b1;
          valid_d    = 1'b1;
          state_d    = VALID;
        end
      end
      VALID: begin
`ifdef FETCH_PREFETCH_EN
        if (bus.redirect) begin
          fetch_pc_d  = bus.redirectAddr;
          valid_d     = 1'b0;
          buf_valid_d = 1'b0;
          if (mem_req && !ack) begin
            drain_addr_d = fetch_pc_q;
            state_d      = DRAIN;
          end else begin
            state_d = REQ;
          end
        end else if (bus.instrReady) begin
          if (buf_valid_q) begin
            instr_d     = buf_data_q;
            pc_out_d    = buf_addr_q;
            buf_valid_d = 1'b0;
          end else if (ack) begin
            instr_d    = bus.memData;
            pc_out_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 1'b1;
          end else begin
            // Outstanding prefetch (if any) carries on as the REQ-state request.
            valid_d = 1'b0;
            state_d = REQ;
          end
        end else if (ack) begin
          buf_data_d  = bus.memData;
          buf_addr_d  = fetch_pc_q;
          buf_valid_d = 1'b1;
          fetch_pc_d  = fetch_pc_q + 1'b1;
        end
`else
        if (bus.redirect) begin
          fetch_pc_d = bus.redirectAddr;
          valid_d    = 1'b0;
          state_d    = REQ;
        end else if (bus.instrReady) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
`endif
      end
      DRAIN: begin
        // A redirect coinciding with the drained ack still retargets, then fetch restarts.
        if (bus.redirect) begin
          fetch_pc_d = bus.redirectAddr;
          valid_d    = 1'b0;
        end
        if (ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.memReq      = mem_req;
  assign bus.memAddr     = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
  assign bus.instruction = instr_q;
  assign bus.instrValid  = valid_q;
  assign bus.pcOut       = pc_out_q;
  assign bus.pcPlusOne   = pc_out_q + 1'b1;
  assign bus.fetchState  = state_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle table, redirect/drain and reset sequences,
// then random memory latency, stalls and redirects against a program-order model.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_WIDTH(16)) bus ();
  instruction_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic ack, rdy, redir;
    logic [15:0] raddr;
    logic req;
    logic [15:0] addr;
    logic valid;
    logic [15:0] instr, pc, ppo;
  } vec_t;
  vec_t vecs[17];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic rdy, input logic redir,
                       input logic [15:0] raddr, input logic [15:0] data);
    bus.memAck       = ack;
    bus.instrReady   = rdy;
    bus.redirect     = redir;
    bus.redirectAddr = raddr;
    bus.memData      = data;
  endtask

  function automatic logic [79:0] obs();
    return {14'd0, bus.memReq, bus.memAddr, bus.instrValid, bus.instruction, bus.pcOut, bus.pcPlusOne};
  endfunction

  function automatic logic [79:0] pack(input logic req, input logic [15:0] addr, input logic v,
                                       input logic [15:0] instr, input logic [15:0] pc,
                                       input logic [15:0] ppo);
    return {14'd0, req, addr, v, instr, pc, ppo};
  endfunction

  function automatic vec_t mk(input logic ack, input logic rdy, input logic redir,
                              input logic [15:0] raddr, input logic req, input logic [15:0] addr,
                              input logic v, input logic [15:0] instr, input logic [15:0] pc,
                              input logic [15:0] ppo);
    vec_t t;
    t.ack = ack; t.rdy = rdy; t.redir = redir; t.raddr = raddr;
    t.req = req; t.addr = addr; t.valid = v; t.instr = instr; t.pc = pc; t.ppo = ppo;
    return t;
  endfunction

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Random-phase model state: the next word the decoder must see, in program order.
  logic [15:0] exp_pc;
  logic        expect_new;
  logic [15:0] last_instr;
  logic        prev_req, prev_ack;
  logic [15:0] prev_addr;
  int          delivered;

  initial begin
    // Memory answers in the same cycle with addr+0x1000; rows are sampled at each negedge.
    vecs[0]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0001);
    vecs[1]  = mk(1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0001);
    vecs[2]  = mk(1, 1, 0, 16'h0000, 0, 16'h0001, 1, 16'h1000, 16'h0000, 16'h0001);
    vecs[3]  = mk(1, 1, 0, 16'h0000, 1, 16'h0001, 0, 16'h1000, 16'h0000, 16'h0001);
    vecs[4]  = mk(0, 1, 0, 16'h0000, 0, 16'h0002, 1, 16'h1001, 16'h0001, 16'h0002);
    vecs[5]  = mk(1, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h1001, 16'h0001, 16'h0002);
    for (int i = 6; i < 10; i++)
      vecs[i] = mk(1, 0, 0, 16'h0000, 0, 16'h0003, 1, 16'h1002, 16'h0002, 16'h0003);
    vecs[10] = mk(0, 1, 1, 16'h0040, 0, 16'h0003, 1, 16'h1002, 16'h0002, 16'h0003);
    vecs[11] = mk(1, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h1002, 16'h0002, 16'h0003);
    vecs[12] = mk(0, 0, 1, 16'hFFFF, 0, 16'h0041, 1, 16'h1040, 16'h0040, 16'h0041);
    vecs[13] = mk(1, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 16'h1040, 16'h0040, 16'h0041);
    vecs[14] = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0FFF, 16'hFFFF, 16'h0000);
    vecs[15] = mk(1, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0FFF, 16'hFFFF, 16'h0000);
    vecs[16] = mk(0, 0, 0, 16'h0000, 0, 16'h0001, 1, 16'h1000, 16'h0000, 16'h0001);

`ifndef FETCH_PREFETCH_EN
    do_reset();
    for (int r = 0; r < 17; r++) begin
      if (r != 0) @(negedge clk);
      chk($sformatf("row%0d", r), obs(),
          pack(vecs[r].req, vecs[r].addr, vecs[r].valid, vecs[r].instr, vecs[r].pc, vecs[r].ppo));
      drive(vecs[r].ack, vecs[r].rdy, vecs[r].redir, vecs[r].raddr, bus.memAddr + 16'h1000);
    end
`endif

    // Redirect while a request is unacknowledged: ack arrives 3 cycles later, stale word dropped.
    do_reset();
    drive(0, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("drain_req_start", obs(), pack(1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0001));
    drive(0, 0, 1, 16'h0040, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("drain_hold%0d", i), obs(), pack(1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0001));
      drive((i == 2), 0, 0, 16'h0000, 16'hDEAD);
    end
    @(negedge clk);
    chk("drain_new_req", obs(), pack(1, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0001));
    drive(1, 0, 0, 16'h0000, 16'h1040);
    @(negedge clk);
    chk("drain_first_word", {bus.instrValid, bus.instruction, bus.pcOut}, {1'b1, 16'h1040, 16'h0040});

    // Reset asserted while draining takes effect without waiting for a clock edge.
    drive(0, 1, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("pre_drain_req", {bus.memReq, bus.memAddr}, {1'b1, 16'h0041});
    drive(0, 0, 1, 16'h0080, 16'h0000);
    @(negedge clk);
    chk("in_drain", {bus.memReq, bus.memAddr, bus.instrValid}, {1'b1, 16'h0041, 1'b0});
    drive(0, 0, 0, 16'h0000, 16'h0000);
    #2 reset = 1'b1;
    #1 chk("async_reset", obs(), pack(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0001));
    @(negedge clk);
    reset = 1'b0;
    chk("reset_release", obs(), pack(0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0001));
    @(negedge clk);
    chk("restart_fetch", {bus.memReq, bus.memAddr}, {1'b1, 16'h0000});

    // Random phase: every word handed to decode must be the next one in program order.
    do_reset();
    exp_pc = 16'h0000; expect_new = 1'b1; last_instr = 16'h0000;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0000; delivered = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic ack, rdy, redir;
      logic [15:0] raddr;
      if (cyc != 0) @(negedge clk);
      if (prev_req && !prev_ack)
        chk("req_held", {bus.memReq, bus.memAddr}, {1'b1, prev_addr});
      if (bus.instrValid && expect_new) begin
        chk("deliver", {bus.pcOut, bus.instruction, bus.pcPlusOne},
            {exp_pc, word_of(exp_pc), exp_pc + 16'h0001});
        last_instr = bus.instruction;
        expect_new = 1'b0;
        delivered++;
      end else if (!expect_new) begin
        chk("hold", {bus.instrValid, bus.pcOut, bus.instruction}, {1'b1, exp_pc, last_instr});
      end
      ack   = ($urandom_range(0, 2) == 0);
      rdy   = ($urandom_range(0, 9) < 6);
      redir = (cyc >= 2) && ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       raddr = 16'hFFFF;
        1:       raddr = 16'hFFFE;
        default: raddr = 16'($urandom);
      endcase
      drive(ack, rdy, redir, raddr, (ack && bus.memReq) ? word_of(bus.memAddr) : 16'($urandom));
      prev_req = bus.memReq; prev_ack = ack; prev_addr = bus.memAddr;
      if (redir) begin
        exp_pc = raddr;
        expect_new = 1'b1;
      end else if (bus.instrValid && rdy) begin
        exp_pc = exp_pc + 16'h0001;
        expect_new = 1'b1;
      end
    end
    chk("progress", {79'd0, delivered > 200}, 80'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetches 16-bit instruction words from instruction memory and holds the current word for the instruction decoder and controller.
- Owns the fetch PC and runs a single-outstanding request/acknowledge handshake with memory.
- Presents `instruction` plus the valid/ready pair to the decode stage.
- Accepts redirects (branch/jump target) from the controller and flushes any in-flight fetch.

Parameters:
- ADDR_WIDTH, 16, width of the word address / PC.
- RESET_PC, 0, fetch address loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- memAddr  output  ADDR_WIDTH  word address of the current fetch request.
- memReq  output  1  fetch request; held high with stable memAddr until memAck.
- memAck  input  1  memory has valid memData this cycle; sampled only while memReq=1.
- memData  input  16  instruction word returned by memory.
- instruction  output  16  instruction register, feeds the decoder instruction input.
- instrValid  output  1  instruction holds an unconsumed, non-flushed word.
- instrReady  input  1  controller consumes instruction at this edge when instrValid=1.
- pcOut  output  ADDR_WIDTH  address of the word held in instruction.
- pcPlusOne  output  ADDR_WIDTH  pcOut+1 modulo 2^ADDR_WIDTH (JAL link value), combinational.
- redirect  input  1  discard sequential flow, restart fetch at redirectAddr.
- redirectAddr  input  ADDR_WIDTH  redirect target.

Behaviour:
- Reset state (asynchronous): state=IDLE, fetchPC=RESET_PC, memReq=0, memAddr=RESET_PC, instruction=16'h0000, instrValid=0, pcOut=RESET_PC.
- States:
  - IDLE: unconditionally goes to REQ on the next edge.
  - REQ: memReq=1, memAddr=fetchPC. On memAck, memData is written to instruction, fetchPC moves to pcOut, fetchPC increments, and the state goes to VALID. Acknowledge in the same cycle as the first assertion is legal.
  - VALID: instrValid=1, memReq=0. On instrReady, instrValid clears and the state goes to REQ.
  - DRAIN: memReq stays 1 with the old memAddr. memAck is swallowed and nothing is written. On memAck the state goes to REQ with the redirected fetchPC.
- Latency: memAck in cycle N gives instrValid=1 in cycle N+1. Base throughput is at most 1 instruction per 2 cycles.
- Redirect (highest priority, any state except IDLE):
  - fetchPC is set to redirectAddr and instrValid clears at the edge.
  - In VALID, or in REQ with memAck in the same cycle: the returned data is discarded and the state goes to REQ.
  - In REQ without memAck: the state goes to DRAIN. The handshake contract forbids dropping memReq before acknowledge.
  - In DRAIN: fetchPC updates to the newest redirectAddr and the state stays DRAIN.
- redirect and instrReady in the same cycle: redirect wins. The held word counts as consumed, since it is the branch itself.
- PC wrap: fetchPC and pcPlusOne wrap from all-ones to 0 with no error.
- memAck while memReq=0 is ignored.
- instrReady while instrValid=0 is ignored.
- Reset asserted mid-transaction returns everything to the reset state immediately. The memory side must tolerate memReq dropping.

Optional Feature:
- Macro: FETCH_PREFETCH_EN.
- When defined:
  - A one-entry prefetch buffer (16-bit word, address, valid) is added.
  - In VALID with an empty buffer, the unit issues the request for fetchPC. The returned word fills the buffer and fetchPC increments.
  - On instrReady with a full buffer, the buffer moves into instruction/pcOut at that edge. instrValid stays 1 and there is no bubble, giving up to 1 instruction per cycle.
  - redirect clears the buffer. Any in-flight request is drained through DRAIN.
- When undefined: no buffer, and behaviour is exactly as above.

Test Plan:
- Reset release, memory acks every request in the same cycle with memData=addr+16'h1000 -> instruction sequence 16'h1000, 16'h1001, 16'h1002 with pcOut 0,1,2; instrValid one cycle after each ack; instrReady held 1.
- instrReady held 0 for 5 cycles with instrValid=1 -> instruction and pcOut stable, memReq=0 (buffer fills once with FETCH_PREFETCH_EN), no PC advance.
- redirect=1, redirectAddr=16'h0040 in REQ while memAck is delayed 3 cycles -> memAddr stays at old address until ack, stale word never reaches instruction, next request memAddr=16'h0040.
- redirect and instrReady in the same cycle in VALID -> instrValid=0 next cycle, next fetch at redirectAddr.
- Redirect to 16'hFFFF then sequential fetch -> pcOut 16'hFFFF with pcPlusOne 16'h0000, next fetch memAddr 16'h0000.
- Reset asserted during DRAIN -> memReq=0, instrValid=0, memAddr=RESET_PC immediately; fetch restarts at RESET_PC.
